// File: rtl/ifft_butterfly.sv
// Radix-2 DIF inverse butterfly: Out1 = A + B, Out2 = (A - B) * conj(W), three-stage valid/ready pipeline.
// Define IFFT_SCALE_EN to apply a 1/2 scale per stage ahead of output saturation.
module ifft_butterfly #(
  parameter int WIDTH  = 16,
  parameter int FRAC_W = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] A_real,
  input  logic signed [WIDTH-1:0] A_imag,
  input  logic signed [WIDTH-1:0] B_real,
  input  logic signed [WIDTH-1:0] B_imag,
  input  logic signed [WIDTH-1:0] Twiddle_real,
  input  logic signed [WIDTH-1:0] Twiddle_imag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] Out1_real,
  output logic signed [WIDTH-1:0] Out1_imag,
  output logic signed [WIDTH-1:0] Out2_real,
  output logic signed [WIDTH-1:0] Out2_imag,
  output logic                    ovf,
  input  logic                    clr_ovf
);
  localparam int SW = WIDTH + 1;
  localparam int PW = 2 * WIDTH + 1;
  localparam int RW = WIDTH + 3;
  localparam logic signed [PW-1:0] RND  = PW'(1) <<< (FRAC_W - 1);
  localparam logic signed [RW-1:0] SMAX = RW'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [RW-1:0] SMIN = -SMAX - RW'(1);

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic                    v1, v2;
  logic signed [SW-1:0]    s1_sum_r, s1_sum_i, s1_dif_r, s1_dif_i;
  logic signed [WIDTH-1:0] s1_w_r, s1_w_i;
  logic signed [SW-1:0]    s2_sum_r, s2_sum_i;
  logic signed [RW-1:0]    s2_o2_r, s2_o2_i;

  function automatic logic signed [SW-1:0] sx(input logic signed [WIDTH-1:0] x);
    return SW'(x);
  endfunction

  // Each partial product is rounded on its own before the cross terms are combined.
  function automatic logic signed [RW-1:0] rmul(input logic signed [SW-1:0] d,
                                                input logic signed [WIDTH-1:0] w);
    logic signed [PW-1:0] p;
    p = PW'(d) * PW'(w);
    return RW'((p + RND) >>> FRAC_W);
  endfunction

  function automatic logic signed [RW-1:0] scl(input logic signed [RW-1:0] x);
`ifdef IFFT_SCALE_EN
    return (x + RW'(1)) >>> 1;
`else
    return x;
`endif
  endfunction

  function automatic logic clips(input logic signed [RW-1:0] x);
    return (x > SMAX) || (x < SMIN);
  endfunction

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [RW-1:0] x);
    if (x > SMAX) return WIDTH'(SMAX);
    else if (x < SMIN) return WIDTH'(SMIN);
    else return WIDTH'(x);
  endfunction

  logic signed [RW-1:0] m_rr, m_ii, m_ir, m_ri;
  assign m_rr = rmul(s1_dif_r, s1_w_r);
  assign m_ii = rmul(s1_dif_i, s1_w_i);
  assign m_ir = rmul(s1_dif_i, s1_w_r);
  assign m_ri = rmul(s1_dif_r, s1_w_i);

  logic signed [RW-1:0] y1r, y1i, y2r, y2i;
  logic                 clip_any;
  assign y1r      = scl(RW'(s2_sum_r));
  assign y1i      = scl(RW'(s2_sum_i));
  assign y2r      = scl(s2_o2_r);
  assign y2i      = scl(s2_o2_i);
  assign clip_any = clips(y1r) || clips(y1i) || clips(y2r) || clips(y2i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      s1_sum_r  <= '0;
      s1_sum_i  <= '0;
      s1_dif_r  <= '0;
      s1_dif_i  <= '0;
      s1_w_r    <= '0;
      s1_w_i    <= '0;
      s2_sum_r  <= '0;
      s2_sum_i  <= '0;
      s2_o2_r   <= '0;
      s2_o2_i   <= '0;
      Out1_real <= '0;
      Out1_imag <= '0;
      Out2_real <= '0;
      Out2_imag <= '0;
      ovf       <= 1'b0;
    end else begin
      if (adv) begin
        v1        <= in_valid;
        s1_sum_r  <= sx(A_real) + sx(B_real);
        s1_sum_i  <= sx(A_imag) + sx(B_imag);
        s1_dif_r  <= sx(A_real) - sx(B_real);
        s1_dif_i  <= sx(A_imag) - sx(B_imag);
        s1_w_r    <= Twiddle_real;
        s1_w_i    <= Twiddle_imag;
        v2        <= v1;
        s2_sum_r  <= s1_sum_r;
        s2_sum_i  <= s1_sum_i;
        s2_o2_r   <= m_rr + m_ii;
        s2_o2_i   <= m_ir - m_ri;
        out_valid <= v2;
        Out1_real <= sat(y1r);
        Out1_imag <= sat(y1i);
        Out2_real <= sat(y2r);
        Out2_imag <= sat(y2i);
      end
      // A clip landing in the same cycle as clr_ovf keeps the flag set.
      if (adv && v2 && clip_any) ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ifft_butterfly.sv
// Self-checking bench for ifft_butterfly: directed vector table, handshake corner cases and a
// randomized stream scored against a complex-arithmetic reference model.
module tb_ifft_butterfly;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, ovf, clr_ovf = 1'b0;
  logic signed [15:0] A_real = '0, A_imag = '0, B_real = '0, B_imag = '0;
  logic signed [15:0] Twiddle_real = '0, Twiddle_imag = '0;
  logic signed [15:0] Out1_real, Out1_imag, Out2_real, Out2_imag;
  logic [63:0] outs;

  always #5 clk = ~clk;

  ifft_butterfly #(.WIDTH(16), .FRAC_W(15)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A_real(A_real), .A_imag(A_imag), .B_real(B_real), .B_imag(B_imag),
    .Twiddle_real(Twiddle_real), .Twiddle_imag(Twiddle_imag),
    .out_valid(out_valid), .out_ready(out_ready),
    .Out1_real(Out1_real), .Out1_imag(Out1_imag), .Out2_real(Out2_real), .Out2_imag(Out2_imag),
    .ovf(ovf), .clr_ovf(clr_ovf)
  );

  assign outs = {Out1_real, Out1_imag, Out2_real, Out2_imag};

  typedef struct { int o1r, o1i, o2r, o2i; } exp_t;
  typedef struct { int ar, ai, br, bi, wr, wi; int o1r, o1i, o2r, o2i; bit ovf; } vec_t;

  exp_t q[$];
  vec_t vecs[5];
  int n_cmp = 0, n_err = 0, n_rx = 0;
  bit mon_en = 0, hold_chk = 0;
  logic [63:0] prev_o;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: complex sum, and difference times the conjugated twiddle, with each
  // Q1.15 partial product rounded half-up to the nearest integer.
  function automatic longint rnd(input longint p);
    return (p + 16384) >>> 15;
  endfunction

  function automatic longint scale(input longint x);
`ifdef IFFT_SCALE_EN
    return (x + 1) >>> 1;
`else
    return x;
`endif
  endfunction

  function automatic int sat(input longint x, inout bit c);
    if (x > 32767) begin c = 1; return 32767; end
    if (x < -32768) begin c = 1; return -32768; end
    return int'(x);
  endfunction

  function automatic exp_t model(input int ar, ai, br, bi, wr, wi, output bit clip);
    exp_t e;
    longint dr, di;
    dr = longint'(ar) - br;
    di = longint'(ai) - bi;
    clip = 0;
    e.o1r = sat(scale(longint'(ar) + br), clip);
    e.o1i = sat(scale(longint'(ai) + bi), clip);
    e.o2r = sat(scale(rnd(dr * wr) + rnd(di * wi)), clip);
    e.o2i = sat(scale(rnd(di * wr) - rnd(dr * wi)), clip);
    return e;
  endfunction

  function automatic logic [63:0] pack(input int a, b, c, d);
    return {16'(a), 16'(b), 16'(c), 16'(d)};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    bit c;
    if (mon_en && !rst) begin
      if (hold_chk) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", outs, prev_o);
      end
      if (in_valid && in_ready) begin
        e = model(A_real, A_imag, B_real, B_imag, Twiddle_real, Twiddle_imag, c);
        q.push_back(e);
      end
      if (out_valid && out_ready) begin
        check("out_expected", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("stream_data", outs, pack(e.o1r, e.o1i, e.o2r, e.o2i));
        end
        n_rx++;
      end
      hold_chk = out_valid && !out_ready;
      prev_o   = outs;
    end
  end

  task automatic set_in(input bit v, input int ar, ai, br, bi, wr, wi);
    in_valid = v;
    A_real = 16'(ar); A_imag = 16'(ai); B_real = 16'(br); B_imag = 16'(bi);
    Twiddle_real = 16'(wr); Twiddle_imag = 16'(wi);
  endtask

  task automatic set_rand(input bit v);
    set_in(v, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    if ($urandom_range(0, 7) == 0) Twiddle_imag = -16'sd32768;
    if ($urandom_range(0, 7) == 0) Twiddle_real = -16'sd32768;
  endtask

  task automatic run_vec(input int i);
    bit found;
    @(posedge clk); #1 clr_ovf = 1;
    @(posedge clk); #1 clr_ovf = 0;
    set_in(1, vecs[i].ar, vecs[i].ai, vecs[i].br, vecs[i].bi, vecs[i].wr, vecs[i].wi);
    @(negedge clk);
    check($sformatf("clr_ovf_v%0d", i), 64'(ovf), 64'd0);
    @(posedge clk); #1 in_valid = 0;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (out_valid) found = 1;
    end
    check($sformatf("vec%0d_timeout", i), 64'(found), 64'd1);
    if (found) begin
      check($sformatf("vec%0d_out", i), outs,
            pack(vecs[i].o1r, vecs[i].o1i, vecs[i].o2r, vecs[i].o2i));
      check($sformatf("vec%0d_ovf", i), 64'(ovf), 64'(vecs[i].ovf));
    end
  endtask

  task automatic drain();
    in_valid = 0; out_ready = 1;
    for (int k = 0; k < 12 && q.size() != 0; k++) @(posedge clk);
    #1;
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    bit found;
    int lat, sent, rx0, stall;
    bit ivh[20], ovh[20];

`ifdef IFFT_SCALE_EN
    vecs[0] = '{256, 0, 256, 0, 32767, 0,        256, 0, 0, 0, 0};
    vecs[1] = '{256, 512, 0, 0, 0, -32768,       128, 256, -256, 128, 0};
    vecs[2] = '{32767, -32768, 32767, -32768, 32767, 0, 32767, -32768, 0, 0, 0};
    vecs[3] = '{1000, -2000, -3000, 500, 23170, -23170, -1000, -750, 2298, 530, 0};
    vecs[4] = '{-32768, 0, 32767, 0, -32768, 0,  0, 0, 32767, 0, 1};
`else
    vecs[0] = '{256, 0, 256, 0, 32767, 0,        512, 0, 0, 0, 0};
    vecs[1] = '{256, 512, 0, 0, 0, -32768,       256, 512, -512, 256, 0};
    vecs[2] = '{32767, -32768, 32767, -32768, 32767, 0, 32767, -32768, 0, 0, 1};
    vecs[3] = '{1000, -2000, -3000, 500, 23170, -23170, -2000, -1500, 4596, 1060, 0};
    vecs[4] = '{-32768, 0, 32767, 0, -32768, 0,  -1, 0, 32767, 0, 1};
`endif

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_outs", outs, 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 0;
    mon_en = 1;

    for (int i = 0; i < 5; i++) run_vec(i);

    // Clip arriving while clr_ovf is held high: set must win, then clear takes over.
    @(posedge clk); #1 clr_ovf = 1;
    set_in(1, vecs[4].ar, vecs[4].ai, vecs[4].br, vecs[4].bi, vecs[4].wr, vecs[4].wi);
    @(posedge clk); #1 in_valid = 0;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (out_valid) found = 1;
    end
    check("setwins_timeout", 64'(found), 64'd1);
    check("ovf_set_wins", 64'(ovf), 64'd1);
    @(negedge clk);
    check("ovf_clr_after", 64'(ovf), 64'd0);
    @(posedge clk); #1 clr_ovf = 0;

    // Six beats with a 4-cycle output stall after the first result.
    sent = 0; rx0 = n_rx; stall = 0;
    for (int cyc = 0; cyc < 40 && (n_rx - rx0) < 6; cyc++) begin
      @(posedge clk); #1;
      if (sent < 6) set_rand(1); else in_valid = 0;
      if (n_rx > rx0 && stall < 4) begin out_ready = 0; stall++; end
      else out_ready = 1;
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      if (!out_ready) check("in_ready_stall", 64'(in_ready), 64'd0);
    end
    check("stall_delivered", 64'(n_rx - rx0), 64'd6);
    check("stall_cycles", 64'(stall), 64'd4);
    @(posedge clk); #1 drain();

    // Alternating input valid: output valid follows three cycles later.
    repeat (3) @(posedge clk);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1 set_rand(k % 2 == 0);
      @(negedge clk);
      ivh[k] = in_valid;
      ovh[k] = out_valid;
    end
    @(posedge clk); #1 in_valid = 0;
    for (int k = 0; k < 20; k++)
      check($sformatf("toggle_c%0d", k), 64'(ovh[k]), 64'(k >= 3 ? ivh[k-3] : 1'b0));
    drain();

    // Randomized traffic with random backpressure.
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      set_rand($urandom_range(0, 3) != 0);
      out_ready = $urandom_range(0, 3) != 0;
    end
    @(posedge clk); #1 drain();

    // Asynchronous reset with beats in flight.
    run_vec(4);
    @(posedge clk); #1 set_rand(1);
    @(posedge clk); #1 set_rand(1);
    @(posedge clk); #1 set_rand(1);
    @(posedge clk); #3;
    mon_en = 0;
    rst = 1;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_outs", outs, 64'd0);
    check("arst_ovf", 64'(ovf), 64'd0);
    q.delete();
    hold_chk = 0;
    @(posedge clk); #1 rst = 0;
    set_in(1, 300, -700, 100, 50, 16384, -8192);
    mon_en = 1;
    lat = 0; found = 0;
    for (int k = 0; k < 8 && !found; k++) begin
      @(posedge clk); #1;
      lat++;
      in_valid = 0;
      if (out_valid) found = 1;
    end
    check("post_rst_found", 64'(found), 64'd1);
    check("post_rst_latency", 64'(lat), 64'd3);
    @(posedge clk); #1 drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ifft_butterfly.md
Name: ifft_butterfly

Overview:
Radix-2 decimation-in-frequency inverse butterfly for the IFFT path, the inverse direction of the forward DIT butterfly.
- Computes Out1 = A + B and Out2 = (A - B) * conj(W).
- Data is Q8.8 complex, twiddle is Q1.15 complex.
- Three-stage pipeline with valid/ready handshakes on both sides, sitting between the IFFT stage memory reader and writer.

Parameters:
WIDTH, 16, bits per real/imag sample (Q8.8) and per twiddle component (Q1.15)
FRAC_W, 15, twiddle fractional bits; product rounding constant is 1<<(FRAC_W-1)

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept an input this cycle
A_real, A_imag  in  WIDTH each  first operand, signed Q8.8
B_real, B_imag  in  WIDTH each  second operand, signed Q8.8
Twiddle_real, Twiddle_imag  in  WIDTH each  W, signed Q1.15 (conjugation is internal)
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts output
Out1_real, Out1_imag, Out2_real, Out2_imag  out  WIDTH each  signed results
ovf  out  1  sticky saturation flag
clr_ovf  in  1  synchronous clear of ovf

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous, active-high.
- Reset values (applied immediately on rst): all Out* = 0, out_valid = 0, all stage valids = 0, ovf = 0.
- Global advance: adv = !out_valid || out_ready.
  - in_ready = adv, combinational; it is 1 out of reset.
  - Input is accepted when in_valid && in_ready.
  - All three stages shift only when adv = 1; otherwise every register holds.
- Latency: 3 clk from acceptance to out_valid when out_ready stays high. Throughput is 1 beat/clk. Bubbles propagate as valid = 0.
- S1 (register):
  - sum = A + B and diff = A - B, each sign-extended to WIDTH+1 bits.
  - Register Twiddle alongside them.
- S2 (register), computed from diff (d) and W:
  - Products p = d x w are (2*WIDTH+1)-bit signed.
  - Each product is rounded individually: r = (p + 2^14) >>> 15.
  - Out2 real = r(dr*wr) + r(di*wi).
  - Out2 imag = r(di*wr) - r(dr*wi).
  - Results are held in WIDTH+3 bits. Pass sum through.
  - W is never negated, so wi = -32768 is exact.
- S3 (register):
  - Optional scaling (see Optional Feature), then saturate each component to [-32768, 32767].
  - Set ovf if any of the 4 components clipped while the S3 beat is valid and advancing.
- ovf priority: clr_ovf clears ovf unless a clip occurs in the same cycle; set wins.
- Output stability: while out_valid && !out_ready, all Out* and out_valid hold stable.
- Reset mid-operation: in-flight beats are discarded with no partial output, and the block resumes accepting on the first clk after rst deasserts.

Optional Feature:
IFFT_SCALE_EN
- Defined: S3 applies a per-stage 1/2 scale before saturation, y = (x + 1) >>> 1, on all 4 components. Over log2(32) = 5 stages this implements the 1/N of the IFFT.
- Undefined: no scaling, saturation only.
- Latency and handshake are identical in both builds.

Test Plan:
1. A=(256,0), B=(256,0), W=(32767,0), out_ready=1 -> 3 clk later Out1=(512,0), Out2=(0,0); with IFFT_SCALE_EN, Out1=(256,0).
2. A=(256,512), B=(0,0), W=(0,-32768) -> Out1=(256,512), Out2=(-512,256), i.e. multiply by +j; ovf stays 0.
3. A=(32767,-32768), B=(32767,-32768), W=(32767,0), no scaling -> Out1=(32767,-32768), Out2=(0,0), ovf=1. Then pulse clr_ovf with no clip -> ovf=0. With IFFT_SCALE_EN -> Out1=(32767,-32768) and ovf=0.
4. Stream 6 distinct beats; drop out_ready for 4 clk after the first output -> in_ready=0 during the stall, outputs held stable, all 6 results delivered in order with none duplicated.
5. Assert rst asynchronously mid-clock with 3 beats in flight -> out_valid=0 and Out*=0 immediately, ovf=0; after release, a new beat's result emerges after 3 clk.
6. in_valid toggled every other clk with out_ready=1 -> out_valid toggles with the same pattern, delayed by 3 clk.
